// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. A radix-2 shift-add multiplier and a restoring
// divider share one 2*Data_Width accumulator. Divide corner cases take a one-cycle fast path.
module muldiv_unit #(
   parameter int Data_Width = 32,
   parameter int Op_Width   = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [Op_Width-1:0]   opsel_i,
   input  logic [Data_Width-1:0] operand_a_i,
   input  logic [Data_Width-1:0] operand_b_i,
   input  logic                  flush_i,
   output logic                  valid_o,
   output logic [Data_Width-1:0] result_o,
   output logic                  busy_o
);
   localparam int CW = $clog2(Data_Width);
   localparam logic [CW-1:0] LAST_CNT = CW'(Data_Width - 1);
   localparam logic [Data_Width-1:0] MIN_SIGNED = {1'b1, {(Data_Width-1){1'b0}}};

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [CW-1:0]           r_cnt;
   logic [2*Data_Width-1:0] r_acc;
   logic [Data_Width-1:0]   r_opnd;
   logic [2:0]              r_op;
   logic                    r_neg;
   logic [Data_Width-1:0]   r_result;

   logic [2:0]              w_op;
   logic                    w_sa;
   logic                    w_sb;
   logic                    w_neg;
   logic [Data_Width-1:0]   w_mag_a;
   logic [Data_Width-1:0]   w_mag_b;
   logic                    w_accept;
   logic                    w_b_zero;
   logic                    w_fast;
   logic [Data_Width-1:0]   w_fast_result;
   logic [Data_Width:0]     w_add;
   logic [Data_Width:0]     w_shift;
   logic [Data_Width:0]     w_diff;
   logic [2*Data_Width-1:0] w_acc_step;
   logic [2*Data_Width-1:0] w_prod;
   logic [Data_Width-1:0]   w_quo;
   logic [Data_Width-1:0]   w_rem;
   logic [Data_Width-1:0]   w_final;

   // Encodings beyond the eight RV32M ops fall back to MUL.
   always_comb begin
      w_op = opsel_i[2:0];
      if ((opsel_i >> 3) != '0) begin
         w_op = OP_MUL;
      end
   end

   always_comb begin
      w_sa = 1'b0;
      w_sb = 1'b0;
      case (w_op)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            w_sa = operand_a_i[Data_Width-1];
            w_sb = operand_b_i[Data_Width-1];
         end
         OP_MULHSU: w_sa = operand_a_i[Data_Width-1];
         default: ;
      endcase
      w_neg   = (w_op == OP_REM) ? w_sa : (w_sa ^ w_sb);
      w_mag_a = w_sa ? (~operand_a_i + 1'b1) : operand_a_i;
      w_mag_b = w_sb ? (~operand_b_i + 1'b1) : operand_b_i;
   end

   assign w_accept = (r_state == IDLE) && valid_i && !flush_i;
   assign w_b_zero = (operand_b_i == '0);

   always_comb begin
      w_fast        = 1'b0;
      w_fast_result = '0;
      if (w_op[2] && w_b_zero) begin
         w_fast        = 1'b1;
         w_fast_result = (w_op == OP_DIV || w_op == OP_DIVU) ? '1 : operand_a_i;
      end else if ((w_op == OP_DIV || w_op == OP_REM) &&
                   operand_a_i == MIN_SIGNED && operand_b_i == '1) begin
         w_fast        = 1'b1;
         w_fast_result = (w_op == OP_DIV) ? MIN_SIGNED : '0;
      end
   end

   // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
   always_comb begin
      w_add   = {1'b0, r_acc[2*Data_Width-1:Data_Width]} +
                (r_acc[0] ? {1'b0, r_opnd} : '0);
      w_shift = {r_acc[2*Data_Width-1:Data_Width], r_acc[Data_Width-1]};
      w_diff  = w_shift - {1'b0, r_opnd};
      if (!r_op[2]) begin
         w_acc_step = {w_add, r_acc[Data_Width-1:1]};
      end else if (w_diff[Data_Width]) begin
         w_acc_step = {w_shift[Data_Width-1:0], r_acc[Data_Width-2:0], 1'b0};
      end else begin
         w_acc_step = {w_diff[Data_Width-1:0], r_acc[Data_Width-2:0], 1'b1};
      end
   end

   always_comb begin
      w_prod = r_neg ? (~w_acc_step + 1'b1) : w_acc_step;
      w_quo  = r_neg ? (~w_acc_step[Data_Width-1:0] + 1'b1) : w_acc_step[Data_Width-1:0];
      w_rem  = r_neg ? (~w_acc_step[2*Data_Width-1:Data_Width] + 1'b1)
                     : w_acc_step[2*Data_Width-1:Data_Width];
      case (r_op)
         OP_MUL:                       w_final = w_prod[Data_Width-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*Data_Width-1:Data_Width];
         OP_DIV, OP_DIVU:              w_final = w_quo;
         default:                      w_final = w_rem;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      ready_o      = 1'b0;
      valid_o      = 1'b0;
      busy_o       = 1'b1;
      case (r_state)
         IDLE: begin
            ready_o = 1'b1;
            busy_o  = 1'b0;
            if (w_accept) begin
               w_state_next = w_fast ? DONE : CALC;
            end
         end
         CALC: begin
            if (flush_i) begin
               w_state_next = IDLE;
            end else if (r_cnt == LAST_CNT) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            valid_o      = !flush_i;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_op     <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
      end else if (w_accept) begin
         r_op  <= w_op;
         r_neg <= w_neg;
         r_cnt <= '0;
         if (w_op[2]) begin
            r_acc  <= {{Data_Width{1'b0}}, w_mag_a};
            r_opnd <= w_mag_b;
         end else begin
            r_acc  <= {{Data_Width{1'b0}}, w_mag_b};
            r_opnd <= w_mag_a;
         end
         if (w_fast) begin
            r_result <= w_fast_result;
         end
      end else if (r_state == CALC && !flush_i) begin
         r_acc <= w_acc_step;
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == LAST_CNT) begin
            r_result <= w_final;
         end
      end
   end

   assign result_o = r_result;

endmodule
